// File: rtl/acumulador_placar_serial_if.sv
// Request/response bundle for the serial scoreboard accumulator.
// The master side issues point requests; the slave side reports progress and scores.
interface acumulador_placar_serial_if #(
    parameter int WIDTH   = 7,
    parameter int CANAIS  = 2,
    parameter int CANAL_W = 1,
    parameter int PASSO_W = 2
);
    logic                     clr;
    logic                     en;
    logic [CANAL_W-1:0]       canal;
    logic [PASSO_W-1:0]       valor;
    logic                     sub;
    logic                     busy;
    logic                     done;
    logic                     sat;
    logic [CANAIS*WIDTH-1:0]  placar;

    modport master (
        output clr, en, canal, valor, sub,
        input  busy, done, sat, placar
    );

    modport slave (
        input  clr, en, canal, valor, sub,
        output busy, done, sat, placar
    );
endinterface

// File: rtl/acumulador_placar_serial.sv
// Multi-channel saturating score accumulator using one reused 1-bit full-adder slice.
// Each request takes WIDTH serial add cycles, one clamp/writeback cycle and one done cycle.
module acumulador_placar_serial #(
    parameter int WIDTH   = 7,
    parameter int CANAIS  = 2,
    parameter int CANAL_W = 1,
    parameter int PASSO_W = 2,
    parameter int MAX     = 99
) (
    input  logic                        clk,
    input  logic                        rst,
    acumulador_placar_serial_if.slave   bus
);
    localparam int IDX_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        OCIOSO,
        SOMA,
        AJUSTE,
        FIM
    } estado_t;

    estado_t            estado;
    estado_t            proximo;

    logic [WIDTH-1:0]   score [CANAIS];
    logic [WIDTH-1:0]   score_atual;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   resultado;
    logic [WIDTH-1:0]   valor_ext;
    logic [WIDTH-1:0]   clamp_valor;
    logic               clamp_sat;
    logic               carry;
    logic               carry_next;
    logic               soma_bit;
    logic               b_bit;
    logic               sub_q;
    logic               sat_q;
    logic [CANAL_W-1:0] canal_q;
    logic [IDX_W-1:0]   bit_idx;
    logic               canal_ok;
    logic               aceita;
    logic               ultimo_bit;

    assign canal_ok   = ({1'b0, bus.canal} < (CANAL_W+1)'(CANAIS));
    assign aceita     = (estado == OCIOSO) && bus.en && !bus.clr && canal_ok;
    assign ultimo_bit = (bit_idx == IDX_W'(WIDTH-1));
    assign valor_ext  = {{(WIDTH-PASSO_W){1'b0}}, bus.valor};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // clr overrides every transition and aborts any operation in flight
    always_comb begin
        proximo  = estado;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.sat  = 1'b0;
        case (estado)
            OCIOSO: if (aceita) proximo = SOMA;
            SOMA:   if (ultimo_bit) proximo = AJUSTE;
            AJUSTE: proximo = FIM;
            FIM:    proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
        if (bus.clr) begin
            proximo = OCIOSO;
        end
        bus.busy = (estado != OCIOSO);
        bus.done = (estado == FIM);
        bus.sat  = (estado == FIM) && sat_q;
    end

    always_comb begin
        score_atual = '0;
        for (int k = 0; k < CANAIS; k++) begin
            if (bus.canal == CANAL_W'(k)) begin
                score_atual = score[k];
            end
        end
    end

    // Subtraction is a + ~b + 1: the inverted operand bit plus carry-in = sub
    always_comb begin
        b_bit      = op_b[0] ^ sub_q;
        soma_bit   = op_a[0] ^ b_bit ^ carry;
        carry_next = (op_a[0] & b_bit) | (op_a[0] & carry) | (b_bit & carry);
    end

    // On subtract a final carry of 0 means a borrow, i.e. the score went negative
    always_comb begin
        clamp_valor = resultado;
        clamp_sat   = 1'b0;
        if (!sub_q) begin
            if (carry || (resultado > WIDTH'(MAX))) begin
                clamp_valor = WIDTH'(MAX);
                clamp_sat   = 1'b1;
            end
        end else if (!carry) begin
            clamp_valor = '0;
            clamp_sat   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CANAIS; k++) begin
                score[k] <= '0;
            end
            op_a      <= '0;
            op_b      <= '0;
            resultado <= '0;
            carry     <= 1'b0;
            sub_q     <= 1'b0;
            sat_q     <= 1'b0;
            canal_q   <= '0;
            bit_idx   <= '0;
        end else if (bus.clr) begin
            for (int k = 0; k < CANAIS; k++) begin
                score[k] <= '0;
            end
        end else begin
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        canal_q <= bus.canal;
                        sub_q   <= bus.sub;
                        op_a    <= score_atual;
                        op_b    <= valor_ext;
                        carry   <= bus.sub;
                        bit_idx <= '0;
                    end
                end
                SOMA: begin
                    op_a      <= op_a >> 1;
                    op_b      <= op_b >> 1;
                    resultado <= {soma_bit, resultado[WIDTH-1:1]};
                    carry     <= carry_next;
                    bit_idx   <= bit_idx + IDX_W'(1);
                end
                AJUSTE: begin
                    for (int k = 0; k < CANAIS; k++) begin
                        if (canal_q == CANAL_W'(k)) begin
                            score[k] <= clamp_valor;
                        end
                    end
                    sat_q <= clamp_sat;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.placar = '0;
        for (int k = 0; k < CANAIS; k++) begin
            bus.placar[k*WIDTH +: WIDTH] = score[k];
        end
    end
endmodule
